// File: rtl/uart_rx_if.sv
// Receive-side bundle of the inter-FPGA UART link: serial line in, decoded byte and status out.
// The receiver takes the slave view; the line driver and byte consumer take the master view.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output rx,
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    input  rx_busy
  );

  modport slave (
    input  rx,
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    output rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver for 11-bit frames: start, data MSB first, parity, stop.
// Each byte is delivered with a one-cycle strobe together with its parity and framing status.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned PARITY    = 0
) (
  input logic     clk,
  input logic     reset,
  uart_rx_if.slave bus
);

  localparam int unsigned BIT_CLKS  = CLK_FREQ / BAUD_RATE + 1;
  localparam int unsigned HALF_CLKS = BIT_CLKS / 2;

  localparam logic [31:0] BitLast  = 32'(BIT_CLKS - 1);
  localparam logic [31:0] HalfLast = 32'(HALF_CLKS - 1);

  typedef enum logic [2:0] {
    StWaitIdle,
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] clk_count_q, clk_count_d;
  logic [2:0]  bit_index_q, bit_index_d;
  logic [7:0]  shift_q, shift_d;
  logic        mismatch_q, mismatch_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_busy_q, rx_busy_d;

  logic rx_meta_q, rx_s_q;
  logic parity_exp;

  // Two-flop synchroniser; resetting low forces the receiver to see a high line before re-arming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b0;
      rx_s_q    <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StWaitIdle;
      clk_count_q  <= '0;
      bit_index_q  <= '0;
      shift_q      <= '0;
      mismatch_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_count_q  <= clk_count_d;
      bit_index_q  <= bit_index_d;
      shift_q      <= shift_d;
      mismatch_q   <= mismatch_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rx_busy_q    <= rx_busy_d;
    end
  end

  always_comb begin
    parity_exp = (PARITY != 0) ? ~^shift_q : ^shift_q;

    state_d      = state_q;
    clk_count_d  = clk_count_q;
    bit_index_d  = bit_index_q;
    shift_d      = shift_q;
    mismatch_d   = mismatch_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    rx_busy_d    = rx_busy_q;

    case (state_q)
      StWaitIdle: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        if (!rx_s_q) begin
          state_d     = StStart;
          clk_count_d = '0;
          rx_busy_d   = 1'b1;
        end
      end

      StStart: begin
        if (clk_count_q == HalfLast) begin
          clk_count_d = '0;
          if (rx_s_q) begin
            // Line back high at mid-start: a glitch, not a frame.
            state_d   = StIdle;
            rx_busy_d = 1'b0;
          end else begin
            state_d     = StData;
            bit_index_d = 3'd7;
          end
        end else begin
          clk_count_d = clk_count_q + 32'd1;
        end
      end

      StData: begin
        if (clk_count_q == BitLast) begin
          clk_count_d = '0;
          shift_d     = {shift_q[6:0], rx_s_q};
          bit_index_d = bit_index_q - 3'd1;
          if (bit_index_q == 3'd0) begin
            state_d = StParity;
          end
        end else begin
          clk_count_d = clk_count_q + 32'd1;
        end
      end

      StParity: begin
        if (clk_count_q == BitLast) begin
          clk_count_d = '0;
          mismatch_d  = (rx_s_q != parity_exp);
          state_d     = StStop;
        end else begin
          clk_count_d = clk_count_q + 32'd1;
        end
      end

      StStop: begin
        if (clk_count_q == BitLast) begin
          clk_count_d  = '0;
          data_out_d   = shift_q;
          data_valid_d = 1'b1;
          parity_err_d = mismatch_q;
          frame_err_d  = ~rx_s_q;
          rx_busy_d    = 1'b0;
          // A low stop bit may be a break; wait for the line to return high before re-arming.
          state_d      = rx_s_q ? StIdle : StWaitIdle;
        end else begin
          clk_count_d = clk_count_q + 32'd1;
        end
      end

      default: begin
        state_d = StWaitIdle;
      end
    endcase
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an even- and an odd-parity receiver share one serial line; expected bytes,
// status and strobe cycle are queued per frame and checked by a monitor on each strobe.
module tb_uart_rx;

  localparam int unsigned ClkFreq  = 1600;
  localparam int unsigned BaudRate = 100;
  localparam int unsigned BitClks  = 17;
  // Strobe cycle relative to the cycle rx is driven low: 2 sync + 8 + 170 + 1.
  localparam int unsigned StrobeLat = 181;

  typedef struct {
    logic [7:0]  data;
    logic        perr_even;
    logic        perr_odd;
    logic        ferr;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_line = 1'b1;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  exp_t        q_even[$];
  exp_t        q_odd[$];

  uart_rx_if bus_e ();
  uart_rx_if bus_o ();

  assign bus_e.rx = rx_line;
  assign bus_o.rx = rx_line;

  uart_rx #(
    .CLK_FREQ (ClkFreq),
    .BAUD_RATE(BaudRate),
    .PARITY   (0)
  ) dut_even (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_e)
  );

  uart_rx #(
    .CLK_FREQ (ClkFreq),
    .BAUD_RATE(BaudRate),
    .PARITY   (1)
  ) dut_odd (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; must be entered #1 after a posedge and returns at the same phase.
  task automatic drive_frame(input logic [7:0] d, input logic p, input logic s, input bit push);
    logic [10:0] bits;
    exp_t        e;
    bits = {1'b0, d, p, s};
    if (push) begin
      e.data      = d;
      e.perr_even = (p != ^d);
      e.perr_odd  = (p != ~^d);
      e.ferr      = ~s;
      e.cyc       = cyc + StrobeLat;
      q_even.push_back(e);
      q_odd.push_back(e);
    end
    for (int i = 10; i >= 0; i--) begin
      rx_line = bits[i];
      step(BitClks);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus_e.data_valid) begin
      if (q_even.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL even_unexpected_strobe: got data 0x%0h, expected no strobe (cycle %0d)",
                 bus_e.data_out, cyc);
      end else begin
        e = q_even.pop_front();
        check("even_data", 32'(bus_e.data_out), 32'(e.data));
        check("even_parity_err", 32'(bus_e.parity_err), 32'(e.perr_even));
        check("even_frame_err", 32'(bus_e.frame_err), 32'(e.ferr));
        check("even_strobe_cycle", cyc, e.cyc);
      end
    end
    if (bus_o.data_valid) begin
      if (q_odd.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL odd_unexpected_strobe: got data 0x%0h, expected no strobe (cycle %0d)",
                 bus_o.data_out, cyc);
      end else begin
        e = q_odd.pop_front();
        check("odd_data", 32'(bus_o.data_out), 32'(e.data));
        check("odd_parity_err", 32'(bus_o.parity_err), 32'(e.perr_odd));
        check("odd_frame_err", 32'(bus_o.frame_err), 32'(e.ferr));
        check("odd_strobe_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    bit saw_busy;

    // Reset state.
    reset   = 1'b1;
    rx_line = 1'b1;
    step(3);
    check("rst_data_out", 32'(bus_e.data_out), 32'h0);
    check("rst_data_valid", 32'(bus_e.data_valid), 32'h0);
    check("rst_parity_err", 32'(bus_e.parity_err), 32'h0);
    check("rst_frame_err", 32'(bus_e.frame_err), 32'h0);
    check("rst_rx_busy", 32'(bus_o.rx_busy), 32'h0);
    reset = 1'b0;
    step(10);

    // 1: 0xA5, parity 0 (clean for even, error for odd).
    drive_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    step(20);

    // 2: 0x3C with parity bit 1 (error for even, clean for odd).
    drive_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    step(20);

    // 3: 0x81 with a low stop bit, line kept low, then a clean 0x55.
    drive_frame(8'h81, 1'b0, 1'b0, 1'b1);
    step(40);
    check("break_busy_even", 32'(bus_e.rx_busy), 32'h0);
    check("break_busy_odd", 32'(bus_o.rx_busy), 32'h0);
    rx_line = 1'b1;
    step(20);
    drive_frame(8'h55, 1'b0, 1'b1, 1'b1);
    step(20);

    // 4: 5-clock glitch on an idle line.
    rx_line  = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) rx_line = 1'b1;
      step(1);
      if (bus_e.rx_busy) saw_busy = 1'b1;
    end
    check("glitch_busy_rose", 32'(saw_busy), 32'h1);
    check("glitch_busy_fell", 32'(bus_e.rx_busy), 32'h0);
    step(20);

    // 5: 0x00 and 0xFF back-to-back, no gap.
    drive_frame(8'h00, 1'b0, 1'b1, 1'b1);
    drive_frame(8'hFF, 1'b0, 1'b1, 1'b1);
    step(20);

    // 6: reset from data bit 4 of 0x96 until the low parity bit, then 0x5A.
    fork
      drive_frame(8'h96, 1'b0, 1'b1, 1'b0);
      begin
        step(4 * BitClks + 8);
        reset = 1'b1;
        step(2);
        check("midreset_data_out", 32'(bus_e.data_out), 32'h0);
        check("midreset_rx_busy", 32'(bus_e.rx_busy), 32'h0);
        step(9 * BitClks + 7 - (4 * BitClks + 8) - 2);
        reset = 1'b0;
      end
    join
    step(20);
    drive_frame(8'h5A, 1'b0, 1'b1, 1'b1);

    // Bounded drain: every queued frame must have been strobed by now.
    step(250);
    check("even_queue_drained", 32'(q_even.size()), 32'h0);
    check("odd_queue_drained", 32'(q_odd.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
